// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi decoder blocks.
// Holds the default code parameters, the FSM state type used by the
// traceback engine, and a helper for sizing the survivor time index.
package viterbi_pkg;

  localparam int K_DEF = 3;
  localparam int M_DEF = K_DEF - 1;
  localparam int D_DEF = 6;

  // Width of an index into D survivor rows; never narrower than one bit.
  function automatic int time_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_BUSY = 1'b1
  } fsm_e;

endpackage

// File: rtl/tb_mod_dec.sv
// Modulo-D decrement of the survivor time index.
// Ports:
//   value - current time index, 0..D-1
//   dec   - (value == 0) ? D-1 : value-1
module tb_mod_dec #(
  parameter int D = 6,
  parameter int W = 3
) (
  input  logic [W-1:0] value,
  output logic [W-1:0] dec
);

  // D need not be a power of two, so zero wraps explicitly to D-1
  // instead of relying on the natural 2^W underflow.
  assign dec = (value == '0) ? W'(D - 1) : value - 1'b1;

endmodule

// File: rtl/traceback_v2_unit.sv
// Serial traceback engine for a Viterbi decoder.
// Each accepted start walks the external survivor memory backwards from
// (start_time, start_state), one row per clock, for D rows, and emits the
// survivor bit read at the oldest row as the decoded bit.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   start                    - one-cycle traceback request (ignored while busy)
//   start_time, start_state  - newest row and starting state
//   force_state0             - begin from state 0 regardless of start_state
//   tb_time, tb_state        - survivor memory read address (registered)
//   tb_surv_bit              - combinational read data for that address
//   busy                     - traceback in progress
//   dec_bit_valid, dec_bit   - one-cycle result pulse and the held result
module traceback_v2_unit
  import viterbi_pkg::*;
#(
  parameter int K = K_DEF,
  parameter int M = K - 1,
  parameter int D = D_DEF,
  localparam int TIME_W = time_w(D)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TIME_W-1:0] start_time,
  input  logic [M-1:0]      start_state,
  input  logic              force_state0,
  output logic [TIME_W-1:0] tb_time,
  output logic [M-1:0]      tb_state,
  input  logic              tb_surv_bit,
  output logic              busy,
  output logic              dec_bit_valid,
  output logic              dec_bit
);

  fsm_e              fsm_q;
  logic [TIME_W-1:0] step_cnt;
  logic [TIME_W-1:0] prev_time;
  logic [M-1:0]      shifted_state;

  tb_mod_dec #(
    .D(D),
    .W(TIME_W)
  ) u_dec (
    .value(tb_time),
    .dec  (prev_time)
  );

  // Predecessor state: the survivor bit shifts in at the LSB; a
  // single-bit state is simply replaced by it.
  generate
    if (M == 1) begin : g_state_m1
      assign shifted_state = tb_surv_bit;
    end else begin : g_state_mn
      assign shifted_state = {tb_state[M-2:0], tb_surv_bit};
    end
  endgenerate

  // Control FSM with step counter. The read at count D-1 is the oldest
  // row, so its survivor bit is the result rather than another step.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q         <= FSM_IDLE;
      busy          <= 1'b0;
      dec_bit_valid <= 1'b0;
      dec_bit       <= 1'b0;
      tb_time       <= '0;
      tb_state      <= '0;
      step_cnt      <= '0;
    end else begin
      dec_bit_valid <= 1'b0;
      case (fsm_q)
        FSM_IDLE: begin
          if (start) begin
            tb_time  <= start_time;
            tb_state <= force_state0 ? '0 : start_state;
            step_cnt <= '0;
            busy     <= 1'b1;
            fsm_q    <= FSM_BUSY;
          end
        end
        FSM_BUSY: begin
          if (step_cnt == TIME_W'(D - 1)) begin
            dec_bit       <= tb_surv_bit;
            dec_bit_valid <= 1'b1;
            busy          <= 1'b0;
            fsm_q         <= FSM_IDLE;
          end else begin
            tb_state <= shifted_state;
            tb_time  <= prev_time;
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: begin
          fsm_q <= FSM_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_v2_unit.sv
// Self-checking bench for traceback_v2_unit (K=3, D=6).
// Stimulus pushes expected results into a scoreboard queue; a monitor
// pops and compares on every dec_bit_valid pulse. Cycle-level timing and
// address sequences are checked directly from the stimulus process.
module tb_traceback_v2_unit;

  localparam int K = 3;
  localparam int M = 2;
  localparam int D = 6;
  localparam int TW = 3;
  localparam int NS = 4;

  typedef struct {
    bit chk;
    bit val;
  } sb_entry_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] start_time = '0;
  logic [M-1:0]  start_state = '0;
  logic          force_state0 = 1'b0;
  logic [TW-1:0] tb_time;
  logic [M-1:0]  tb_state;
  logic          tb_surv_bit;
  logic          busy;
  logic          dec_bit_valid;
  logic          dec_bit;

  logic          mem [0:D-1][0:NS-1];
  sb_entry_t     sb_q[$];
  int            pass_cnt = 0;
  int            check_cnt = 0;
  int            pulse_cnt = 0;
  int            push_cnt = 0;

  traceback_v2_unit #(.K(K), .M(M), .D(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_time   (start_time),
    .start_state  (start_state),
    .force_state0 (force_state0),
    .tb_time      (tb_time),
    .tb_state     (tb_state),
    .tb_surv_bit  (tb_surv_bit),
    .busy         (busy),
    .dec_bit_valid(dec_bit_valid),
    .dec_bit      (dec_bit)
  );

  always #5 clk = ~clk;

  assign tb_surv_bit = (int'(tb_time) < D) ? mem[tb_time][tb_state] : 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dec_bit_valid) begin
      pulse_cnt++;
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_valid", 1, 0);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        if (e.chk) checkOutput("dec_bit", int'(dec_bit), int'(e.val));
      end
    end
  end

  task automatic fillRow(input int row, input bit v);
    for (int s = 0; s < NS; s++) mem[row][s] = v;
  endtask

  // Issues one start pulse; returns at the negedge just after the accepting edge.
  task automatic applyStimulus(input int t, input int st, input bit f,
                               input bit push, input bit chk, input bit val);
    sb_entry_t e;
    @(negedge clk);
    start_time   = TW'(t);
    start_state  = M'(st);
    force_state0 = f;
    start        = 1'b1;
    if (push) begin
      e.chk = chk;
      e.val = val;
      sb_q.push_back(e);
      push_cnt++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) checkOutput("busy_timeout", 1, 0);
  endtask

  initial begin
    int tseq[6];
    int pstate[6];
    int pbit[6];
    tseq = '{3, 2, 1, 0, 5, 4};

    for (int t = 0; t < D; t++) fillRow(t, 1'b0);

    // Reset
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_valid", int'(dec_bit_valid), 0);
    checkOutput("rst_dec_bit", int'(dec_bit), 0);
    checkOutput("rst_tb_time", int'(tb_time), 0);
    checkOutput("rst_tb_state", int'(tb_state), 0);
    rst = 1'b0;
    @(negedge clk);

    // Stream: row r lands in slot r%6; the oldest row read is r-5
    $display("[TB] stream test");
    for (int r = 0; r < 32; r++) begin
      fillRow(r % D, bit'(r % 2));
      applyStimulus(r % D, 0, 1'b1, 1'b1, r >= 5, bit'((r - 5) % 2));
      waitIdle();
    end

    // Timing with wrap from start_time=3; only row 4 holds ones
    $display("[TB] timing test");
    for (int t = 0; t < D; t++) fillRow(t, 1'b0);
    fillRow(4, 1'b1);
    applyStimulus(3, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("tm_busy", int'(busy), 1);
      checkOutput("tm_tb_time", int'(tb_time), tseq[i]);
      checkOutput("tm_valid_low", int'(dec_bit_valid), 0);
      @(negedge clk);
    end
    checkOutput("tm_busy_fall", int'(busy), 0);
    checkOutput("tm_valid_pulse", int'(dec_bit_valid), 1);
    @(negedge clk);
    checkOutput("tm_valid_clear", int'(dec_bit_valid), 0);
    checkOutput("tm_dec_hold", int'(dec_bit), 1);

    // State path from 2'b10; off-path entries hold the opposite bit
    $display("[TB] state path test");
    tseq   = '{0, 5, 4, 3, 2, 1};
    pstate = '{2, 1, 2, 1, 2, 1};
    pbit   = '{1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 6; i++)
      for (int s = 0; s < NS; s++)
        mem[tseq[i]][s] = (s == pstate[i]) ? bit'(pbit[i]) : ~bit'(pbit[i]);
    applyStimulus(0, 2, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("sp_tb_time", int'(tb_time), tseq[i]);
      checkOutput("sp_tb_state", int'(tb_state), pstate[i]);
      @(negedge clk);
    end
    waitIdle();

    // Start while busy is ignored
    $display("[TB] start while busy test");
    for (int t = 0; t < D; t++) fillRow(t, bit'(t % 2));
    tseq = '{2, 1, 0, 5, 4, 3};
    applyStimulus(2, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checkOutput("sb_tb_time", int'(tb_time), tseq[i]);
      if (i == 1) begin
        start_time = 3'd5;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("sb_busy_fall", int'(busy), 0);
    repeat (3) @(negedge clk);
    checkOutput("sb_no_restart", int'(busy), 0);

    // Reset mid-traceback aborts without a result
    $display("[TB] reset abort test");
    applyStimulus(0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("ra_busy", int'(busy), 0);
    checkOutput("ra_valid", int'(dec_bit_valid), 0);
    checkOutput("ra_tb_time", int'(tb_time), 0);
    repeat (8) @(negedge clk);
    checkOutput("ra_still_idle", int'(busy), 0);
    applyStimulus(0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("ra_restart_busy", int'(busy), 1);
    waitIdle();

    repeat (4) @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);
    checkOutput("pulse_count", pulse_cnt, push_cnt);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
